// File: rtl/queue_writer_module.sv
`default_nettype none
// ============================================================================
// Module   : queue_writer_module
// Purpose  : Write-side end of a KPN FIFO channel. Tokens from a producer are
//            staged in a small ring buffer and drained into a downstream
//            queue_module write port at up to one word per cycle. The write
//            stalls while the queue reports full. A one-cycle eos request
//            drains all staged tokens, writes one EOS_TOKEN marker word, and
//            then parks the block until reset.
// Ports    : clk            rising-edge clock
//            rst_n          synchronous active-low reset
//            in_valid       producer offers in_data this cycle
//            in_data        producer token
//            in_ready       staging can accept (transfer on valid && ready)
//            eos            one-cycle end-of-stream request
//            full           downstream queue full flag
//            wr             registered write strobe to the queue
//            output_1       registered write data, valid when wr=1
//            done           EOS marker written, block idle until reset
//            tokens_written data words written, saturating (optional)
// Options  : QUEUE_WRITER_COUNT_EN - adds the tokens_written counter output
//            and a per-write $display trace.
// Revision : 1.0 - initial release
// ============================================================================
module queue_writer_module #(
  parameter int                     BITS_NUMBER    = 16,
  parameter int                     STAGE_ELEMENTS = 2,
  parameter logic [BITS_NUMBER-1:0] EOS_TOKEN      = 16'hFFFF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [BITS_NUMBER-1:0] in_data,
  output logic                   in_ready,
  input  logic                   eos,
  input  logic                   full,
  output logic                   wr,
  output logic [BITS_NUMBER-1:0] output_1,
  output logic                   done
`ifdef QUEUE_WRITER_COUNT_EN
  ,
  output logic [15:0]            tokens_written
`endif
);

  localparam int unsigned             c_depth     = 1 << STAGE_ELEMENTS;
  localparam logic [STAGE_ELEMENTS:0] c_depth_cnt = c_depth[STAGE_ELEMENTS:0];

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_BLOCKED = 3'd2,
    ST_FLUSH   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Staging ring
  logic [BITS_NUMBER-1:0]    r_mem [c_depth];
  logic [STAGE_ELEMENTS-1:0] r_wr_ptr;
  logic [STAGE_ELEMENTS-1:0] r_rd_ptr;
  logic [STAGE_ELEMENTS:0]   r_count;
  logic [STAGE_ELEMENTS:0]   w_count_next;

  logic                      r_eos_pending;
  logic                      r_wr;
  logic [BITS_NUMBER-1:0]    r_data;
  logic                      r_done;

  logic                      w_accepting_state;
  logic                      w_draining_state;
  logic                      w_in_ready;
  logic                      w_accept;
  logic                      w_drain;
  logic                      w_mark;
  logic                      w_eos_seen;

  // --------------------------------------------------------------------------
  // Handshake and write decisions
  // --------------------------------------------------------------------------
  assign w_accepting_state = (r_state == ST_IDLE) || (r_state == ST_WRITE) ||
                             (r_state == ST_BLOCKED);
  assign w_draining_state  = (r_state == ST_WRITE) || (r_state == ST_BLOCKED) ||
                             (r_state == ST_FLUSH);

  assign w_in_ready = (r_count < c_depth_cnt) && w_accepting_state;
  assign w_accept   = in_valid && w_in_ready;

  // BLOCKED drains as soon as full drops so the restart latency is one cycle.
  assign w_drain = w_draining_state && (r_count != '0) && !full;

  // The marker goes out only once the ring is empty, so it is always the
  // last word written and never overtakes a staged token.
  assign w_mark = (r_state == ST_FLUSH) && (r_count == '0) && !full;

  // An eos arriving this cycle is acted on at this edge; the token accepted
  // alongside it is already counted in w_count_next and drains in FLUSH.
  assign w_eos_seen = eos || r_eos_pending;

  assign w_count_next = r_count
                      + (STAGE_ELEMENTS+1)'(w_accept)
                      - (STAGE_ELEMENTS+1)'(w_drain);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_eos_seen) begin
          w_state_next = ST_FLUSH;
        end else if (w_count_next != '0) begin
          w_state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (w_eos_seen) begin
          w_state_next = ST_FLUSH;
        end else if (full) begin
          w_state_next = ST_BLOCKED;
        end else if (w_count_next == '0) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_BLOCKED: begin
        if (w_eos_seen) begin
          w_state_next = ST_FLUSH;
        end else if (!full) begin
          w_state_next = (w_count_next == '0) ? ST_IDLE : ST_WRITE;
        end
      end
      ST_FLUSH: begin
        if (w_mark) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_next = ST_DONE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Staging ring storage (contents are don't-care after reset; the pointers
  // and count being cleared is what discards staged data)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst_n && w_accept) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + STAGE_ELEMENTS'(1);
      end
      if (w_drain) begin
        r_rd_ptr <= r_rd_ptr + STAGE_ELEMENTS'(1);
      end
      r_count <= w_count_next;
    end
  end

  // eos is only latched while the stream is still open; once flushing has
  // started, further eos pulses have nothing to add.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_eos_pending <= 1'b0;
    end else if (eos && w_accepting_state) begin
      r_eos_pending <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Registered write port; data holds its last value while wr is low
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr   <= 1'b0;
      r_data <= '0;
      r_done <= 1'b0;
    end else begin
      r_wr <= w_drain || w_mark;
      if (w_drain) begin
        r_data <= r_mem[r_rd_ptr];
      end else if (w_mark) begin
        r_data <= EOS_TOKEN;
      end
      // done rises the cycle after the marker strobe, so wr and done are
      // never high together.
      r_done <= (r_state == ST_DONE);
    end
  end

  assign in_ready = w_in_ready;
  assign wr       = r_wr;
  assign output_1 = r_data;
  assign done     = r_done;

`ifdef QUEUE_WRITER_COUNT_EN
  // --------------------------------------------------------------------------
  // Data-word counter (marker excluded), saturating at all-ones
  // --------------------------------------------------------------------------
  logic [15:0] r_tokens_written;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tokens_written <= '0;
    end else if (w_drain && (r_tokens_written != 16'hFFFF)) begin
      r_tokens_written <= r_tokens_written + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_drain) begin
      $display("Escribe el siguiente dato: %d", r_mem[r_rd_ptr]);
    end else if (rst_n && w_mark) begin
      $display("Escribe el siguiente dato: %d", EOS_TOKEN);
    end
  end

  assign tokens_written = r_tokens_written;
`endif

endmodule
`default_nettype wire

// File: tb/tb_queue_writer_module.sv
`default_nettype none
// ============================================================================
// Module   : tb_queue_writer_module
// Purpose  : Self-checking bench for queue_writer_module. A table of per-cycle
//            vectors (inputs driven during a cycle, outputs expected just
//            after the following rising edge) covers reset, basic writes,
//            full back-pressure, eos flushing and reset while blocked. A
//            scoreboard sequence streams tokens through the ring while full
//            toggles. With QUEUE_WRITER_COUNT_EN the data counter is checked.
// Revision : 1.0 - initial release
// ============================================================================
module tb_queue_writer_module;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        eos;
  logic        full;
  logic        wr;
  logic [15:0] output_1;
  logic        done;
`ifdef QUEUE_WRITER_COUNT_EN
  logic [15:0] tokens_written;
`endif

  int n_tests;
  int n_fail;

  queue_writer_module #(
    .BITS_NUMBER   (16),
    .STAGE_ELEMENTS(2),
    .EOS_TOKEN     (16'hFFFF)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_valid(in_valid),
    .in_data (in_data),
    .in_ready(in_ready),
    .eos     (eos),
    .full    (full),
    .wr      (wr),
    .output_1(output_1),
    .done    (done)
`ifdef QUEUE_WRITER_COUNT_EN
    ,
    .tokens_written(tokens_written)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_data;
    logic        eos;
    logic        full;
    logic        e_wr;
    logic [15:0] e_out;
    logic        e_ready;
    logic        e_done;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic v, input logic [15:0] d,
                     input logic e, input logic f, input logic ewr,
                     input logic [15:0] eout, input logic erdy, input logic edone);
    vec_t t;
    t.rst_n = r; t.in_valid = v; t.in_data = d; t.eos = e; t.full = f;
    t.e_wr = ewr; t.e_out = eout; t.e_ready = erdy; t.e_done = edone;
    vq.push_back(t);
  endtask

  task automatic drive(input logic r, input logic v, input logic [15:0] d,
                       input logic e, input logic f);
    rst_n = r; in_valid = v; in_data = d; eos = e; full = f;
  endtask

  initial begin
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);

    //   rst v  data     eos full | wr out      rdy done
    // Reset state
    add(0, 0, 16'h0000, 0, 0,   0, 16'h0000, 1, 0);
    add(0, 0, 16'h0000, 0, 0,   0, 16'h0000, 1, 0);
    // Three tokens, queue never full: writes 1,2,3 on consecutive cycles
    add(1, 1, 16'h0001, 0, 0,   0, 16'h0000, 1, 0);
    add(1, 1, 16'h0002, 0, 0,   1, 16'h0001, 1, 0);
    add(1, 1, 16'h0003, 0, 0,   1, 16'h0002, 1, 0);
    add(1, 0, 16'h0000, 0, 0,   1, 16'h0003, 1, 0);
    add(1, 0, 16'h0000, 0, 0,   0, 16'h0003, 1, 0);
    // Fill the ring while full; 5th offer refused
    add(1, 1, 16'h0010, 0, 1,   0, 16'h0003, 1, 0);
    add(1, 1, 16'h0011, 0, 1,   0, 16'h0003, 1, 0);
    add(1, 1, 16'h0012, 0, 1,   0, 16'h0003, 1, 0);
    add(1, 1, 16'h0013, 0, 1,   0, 16'h0003, 0, 0);
    add(1, 1, 16'h0014, 0, 1,   0, 16'h0003, 0, 0);
    // full drops: four back-to-back writes one cycle later
    add(1, 0, 16'h0000, 0, 0,   1, 16'h0010, 1, 0);
    add(1, 0, 16'h0000, 0, 0,   1, 16'h0011, 1, 0);
    add(1, 0, 16'h0000, 0, 0,   1, 16'h0012, 1, 0);
    add(1, 0, 16'h0000, 0, 0,   1, 16'h0013, 1, 0);
    add(1, 0, 16'h0000, 0, 0,   0, 16'h0013, 1, 0);
    // Two staged, then eos together with 0x00AA
    add(1, 1, 16'h0021, 0, 1,   0, 16'h0013, 1, 0);
    add(1, 1, 16'h0022, 0, 1,   0, 16'h0013, 1, 0);
    add(1, 1, 16'h00AA, 1, 1,   0, 16'h0013, 0, 0);
    add(1, 0, 16'h0000, 0, 0,   1, 16'h0021, 0, 0);
    add(1, 0, 16'h0000, 0, 0,   1, 16'h0022, 0, 0);
    add(1, 0, 16'h0000, 0, 0,   1, 16'h00AA, 0, 0);
    add(1, 0, 16'h0000, 0, 0,   1, 16'hFFFF, 0, 0);
    add(1, 1, 16'h0055, 0, 0,   0, 16'hFFFF, 0, 1);
    add(1, 1, 16'h0056, 1, 0,   0, 16'hFFFF, 0, 1);
    // Reset out of DONE, stage three while full, reset while BLOCKED
    add(0, 0, 16'h0000, 0, 0,   0, 16'h0000, 1, 0);
    add(1, 1, 16'h0031, 0, 1,   0, 16'h0000, 1, 0);
    add(1, 1, 16'h0032, 0, 1,   0, 16'h0000, 1, 0);
    add(1, 1, 16'h0033, 0, 1,   0, 16'h0000, 1, 0);
    add(0, 0, 16'h0000, 0, 1,   0, 16'h0000, 1, 0);
    add(1, 0, 16'h0000, 0, 0,   0, 16'h0000, 1, 0);
    add(1, 0, 16'h0000, 0, 0,   0, 16'h0000, 1, 0);
    add(1, 0, 16'h0000, 0, 0,   0, 16'h0000, 1, 0);
    // eos with empty ring: marker waits for full to drop
    add(1, 0, 16'h0000, 1, 0,   0, 16'h0000, 0, 0);
    add(1, 0, 16'h0000, 0, 1,   0, 16'h0000, 0, 0);
    add(1, 0, 16'h0000, 0, 0,   1, 16'hFFFF, 0, 0);
    add(1, 0, 16'h0000, 0, 0,   0, 16'hFFFF, 0, 1);
    // Data word equal to the marker value passes through as data
    add(0, 0, 16'h0000, 0, 0,   0, 16'h0000, 1, 0);
    add(1, 1, 16'hFFFF, 0, 0,   0, 16'h0000, 1, 0);
    add(1, 0, 16'h0000, 0, 0,   1, 16'hFFFF, 1, 0);
    add(1, 0, 16'h0000, 0, 0,   0, 16'hFFFF, 1, 0);

    n_tests = 0;
    n_fail  = 0;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst_n, vq[i].in_valid, vq[i].in_data, vq[i].eos, vq[i].full);
      @(posedge clk);
      #1;
      n_tests++;
      if (wr !== vq[i].e_wr || output_1 !== vq[i].e_out ||
          in_ready !== vq[i].e_ready || done !== vq[i].e_done) begin
        n_fail++;
        $display("FAIL vec%0d: got wr=%0b out=%h rdy=%0b done=%0b, want wr=%0b out=%h rdy=%0b done=%0b",
                 i, wr, output_1, in_ready, done,
                 vq[i].e_wr, vq[i].e_out, vq[i].e_ready, vq[i].e_done);
      end
    end

    // ------------------------------------------------------------------
    // Ten tokens through the 4-deep ring, full toggling every 3 cycles.
    // Ring is empty and IDLE here (last vector above).
    // ------------------------------------------------------------------
    begin
      int   idx;
      int   widx;
      int   cyc;
      logic acc;
      logic f;
      idx  = 0;
      widx = 0;
      cyc  = 0;
      while (widx < 10 && cyc < 200) begin
        f = ((cyc / 3) % 2) == 1;
        drive(1'b1, (idx < 10), 16'h0100 + 16'(idx), 1'b0, f);
        acc = (idx < 10) && in_ready;
        @(posedge clk);
        #1;
        if (acc) idx++;
        if (f) begin
          n_tests++;
          if (wr !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_full_stall cyc%0d: got wr=%0b, want wr=0", cyc, wr);
          end
        end
        if (wr === 1'b1) begin
          n_tests++;
          if (output_1 !== 16'h0100 + 16'(widx)) begin
            n_fail++;
            $display("FAIL stream_order word%0d: got %h, want %h",
                     widx, output_1, 16'h0100 + 16'(widx));
          end
          widx++;
        end
        cyc++;
      end
      n_tests++;
      if (widx != 10) begin
        n_fail++;
        $display("FAIL stream_count: got %0d words, want 10", widx);
      end
      // No duplicate or late words once the ring has drained
      drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
        @(posedge clk);
        #1;
        n_tests++;
        if (wr !== 1'b0 || in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL stream_tail cyc%0d: got wr=%0b rdy=%0b, want wr=0 rdy=1",
                   k, wr, in_ready);
        end
      end
    end

`ifdef QUEUE_WRITER_COUNT_EN
    // ------------------------------------------------------------------
    // Counter: five data words then eos gives 5 (marker excluded)
    // ------------------------------------------------------------------
    begin
      int waited;
      drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      n_tests++;
      if (tokens_written !== 16'd0) begin
        n_fail++;
        $display("FAIL cnt_reset: got %0d, want 0", tokens_written);
      end
      for (int k = 0; k < 5; k++) begin
        drive(1'b1, 1'b1, 16'h0200 + 16'(k), 1'b0, 1'b0);
        @(posedge clk);
        #1;
      end
      drive(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
      waited = 0;
      while (done !== 1'b1 && waited < 50) begin
        @(posedge clk);
        #1;
        waited++;
      end
      n_tests++;
      if (done !== 1'b1 || tokens_written !== 16'd5) begin
        n_fail++;
        $display("FAIL cnt_after_eos: got done=%0b count=%0d, want done=1 count=5",
                 done, tokens_written);
      end
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/queue_writer_module.md
Name: queue_writer_module

Overview:
- Write-side end of the KPN FIFO channel. Sits between a producer process and a downstream queue_module write port.
- Accepts tokens from the producer into an internal staging ring and drains them into the queue, one word per cycle, with blocking-write semantics: the write stalls while the queue reports full.
- Supports a graceful end-of-stream. The block drains all staged tokens, writes one EOS marker word, then parks until reset.

Parameters:
- BITS_NUMBER, 16, token width in bits.
- STAGE_ELEMENTS, 2, log2 of staging depth (2**2 = 4 entries).
- EOS_TOKEN, 16'hFFFF, marker word written after the final token.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  producer offers in_data this cycle.
- in_data  input  BITS_NUMBER  producer token.
- in_ready  output  1  staging can accept; a token transfers when in_valid && in_ready at posedge.
- eos  input  1  one-cycle end-of-stream request from producer.
- full  input  1  downstream queue full flag.
- wr  output  1  registered write strobe to queue; one word per high cycle.
- output_1  output  BITS_NUMBER  registered write data, valid when wr=1.
- done  output  1  EOS marker written; block idle until reset.

Behaviour:
- Reset (rst_n=0 at posedge):
  - wr=0, output_1=0, done=0.
  - Read/write pointers = 0, count = 0, state = IDLE.
  - Staged data is discarded, including when reset lands mid-stream or while BLOCKED.
- Staging ring:
  - Pointers are STAGE_ELEMENTS bits wide and wrap naturally from 2**STAGE_ELEMENTS-1 to 0.
  - count is STAGE_ELEMENTS+1 bits wide.
  - in_ready = (count < 2**STAGE_ELEMENTS) && state is IDLE, WRITE or BLOCKED.
  - Simultaneous accept and drain in the same cycle: count is unchanged, both pointers advance.
- States:
  - IDLE: count==0, wr=0. Go to WRITE when count becomes nonzero. Go to FLUSH when an eos is pending.
  - WRITE:
    - If full==0 at posedge: next cycle wr=1, output_1 = head word, read pointer +1, count -1.
    - If full==1: go to BLOCKED, wr=0, output_1 holds its last value.
    - Go to IDLE when count reaches 0 with no eos pending.
  - BLOCKED: wr=0. Return to WRITE on the first posedge with full==0. Latency from full falling to wr=1 is 1 cycle.
  - FLUSH:
    - in_ready=0. Drains the remaining entries exactly as WRITE does, including the BLOCKED stall on full.
    - When count==0 and full==0: wr=1, output_1=EOS_TOKEN, then go to DONE.
  - DONE: wr=0, done=1, in_ready=0. The block stays here until rst_n=0.
- eos handling:
  - eos is latched into an eos_pending flag; it never drops a token.
  - A token accepted in the same cycle as eos is staged and written before the marker.
  - eos while already in FLUSH or DONE is ignored.
- Write rate and ordering:
  - wr is never high in two consecutive cycles unless full stays 0; maximum rate is 1 word per cycle.
  - Word order on output_1 equals acceptance order.
- Data fidelity: a token equal to EOS_TOKEN in normal data is passed through unchanged. The marker is distinguished only by being the last write before done.

Optional Feature:
- Macro: QUEUE_WRITER_COUNT_EN.
- When defined:
  - Adds output tokens_written [15:0]. It counts data words written (the EOS marker is excluded) and saturates at 16'hFFFF.
  - Reset value is 0.
  - Each write also prints "Escribe el siguiente dato: %d" via $display.
- When undefined: the port and the counter are absent and no $display is issued; all other behaviour is identical.

Test Plan:
- Reset then 3 tokens 0x0001, 0x0002, 0x0003 with full=0 -> wr pulses on 3 cycles, output_1 = 1, 2, 3 in order; done=0.
- Fill staging with 4 tokens while full=1 -> in_ready=0 after the 4th token, wr stays 0; drop full -> 1 cycle later 4 consecutive writes, in_ready returns high.
- Stream 10 tokens through the 4-deep ring with full toggling every 3 cycles -> all 10 written in order; pointer wrap verified; no duplicates or drops.
- eos in the same cycle as token 0x00AA, with 2 tokens already staged -> writes staged0, staged1, 0x00AA, then 0xFFFF; done=1 the next cycle; later in_valid is ignored.
- rst_n=0 while BLOCKED with 3 tokens staged -> next cycle wr=0, output_1=0, in_ready=1; after release with full=0 nothing is written.
- With QUEUE_WRITER_COUNT_EN: 5 tokens followed by eos -> tokens_written=5 after done.
